// File: rtl/alu_mem_unit_pkg.sv
// alu_mem_unit_pkg: opcode encoding and width defaults shared by the ALU and the top level.
// Rev 1.0
`default_nettype none
package alu_mem_unit_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ALU_WIDTH          = 32;
  localparam int ALU_SEL_WIDTH      = 4;

  typedef enum logic [ALU_SEL_WIDTH-1:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_SRA   = 4'b1000,
    ALU_NOR   = 4'b1001,
    ALU_SLTU  = 4'b1010,
    ALU_PASSL = 4'b1011,
    ALU_PASSR = 4'b1100
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_mem_unit_alu.sv
// alu: purely combinational 32-bit ALU; unlisted opcodes produce zero.
// Rev 1.0
`default_nettype none
module alu
  import alu_mem_unit_pkg::*;
(
  input  logic [ALU_WIDTH-1:0]     a_i,
  input  logic [ALU_WIDTH-1:0]     b_i,
  input  logic [ALU_SEL_WIDTH-1:0] sel_i,
  output logic [ALU_WIDTH-1:0]     result_o,
  output logic                     zero_o
);

  logic [4:0]                  shamt;
  logic signed [ALU_WIDTH-1:0] sra_res;
  logic [ALU_WIDTH-1:0]        result;

  assign shamt   = b_i[4:0];
  assign sra_res = $signed(a_i) >>> shamt;

  always_comb begin
    result = '0;
    case (sel_i)
      ALU_AND:   result = a_i & b_i;
      ALU_OR:    result = a_i | b_i;
      ALU_ADD:   result = a_i + b_i;
      ALU_XOR:   result = a_i ^ b_i;
      ALU_SLL:   result = a_i << shamt;
      ALU_SRL:   result = a_i >> shamt;
      ALU_SUB:   result = a_i - b_i;
      ALU_SLT:   result = {{(ALU_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SRA:   result = sra_res;
      ALU_NOR:   result = ~(a_i | b_i);
      ALU_SLTU:  result = {{(ALU_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_PASSL: result = a_i;
      ALU_PASSR: result = b_i;
      default:   result = '0;
    endcase
  end

  assign result_o = result;
  assign zero_o   = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_mem_unit.sv
// alu_mem_unit: single-port RAM on a tri-state data bus, alongside an independent ALU.
// Rev 1.0
`default_nettype none
module alu_mem_unit
  import alu_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = 28,
  parameter int RAM_DEPTH  = 4096
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_WIDTH-1:0]    addr,
  inout  wire  [DATA_WIDTH-1:0]    data,
  input  logic                     cs_input,
  input  logic                     we,
  input  logic                     oe,
  input  logic [ALU_WIDTH-1:0]     left,
  input  logic [ALU_WIDTH-1:0]     right,
  input  logic [ALU_SEL_WIDTH-1:0] alu_sel,
  output logic [ALU_WIDTH-1:0]     alu_out,
  output logic                     alu_zero
);

  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [IDX_W-1:0]      idx;
  logic                  bus_en;

  // Upper address bits alias onto the physical array.
  assign idx = IDX_W'(addr % ADDR_WIDTH'(RAM_DEPTH));

  always_comb begin
    rd_d = rd_q;
    if (cs_input && !we) begin
      rd_d = mem_q[idx];
    end
  end

  // Storage is never cleared; reset only blocks writes and zeroes the read register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
      if (cs_input && we) begin
        mem_q[idx] <= data;
      end
    end
  end

  assign bus_en = reset_n & cs_input & oe & ~we;
  assign data   = bus_en ? rd_q : {DATA_WIDTH{1'bz}};

  alu u_alu (
    .a_i      (left),
    .b_i      (right),
    .sel_i    (alu_sel),
    .result_o (alu_out),
    .zero_o   (alu_zero)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_unit.sv
// tb_alu_mem_unit: directed stimulus with a queue-based scoreboard checked on the falling edge.
// Rev 1.0
`default_nettype none
module tb_alu_mem_unit;

  localparam logic [31:0] PULL = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset_n;
  logic [27:0] addr;
  tri1  [31:0] data;
  logic        cs_input;
  logic        we;
  logic        oe;
  logic [31:0] left;
  logic [31:0] right;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;

  logic        drv_en;
  logic [31:0] drv_val;

  assign data = drv_en ? drv_val : 32'bz;

  alu_mem_unit dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr     (addr),
    .data     (data),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe),
    .left     (left),
    .right    (right),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_alu;
    logic [31:0] val;
    logic        zero;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every pending expectation is compared against the settled outputs.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.is_alu) begin
        if (alu_out !== e.val || alu_zero !== e.zero) begin
          failures++;
          $display("FAIL %s: alu_out=%h alu_zero=%b expected %h/%b",
                   e.name, alu_out, alu_zero, e.val, e.zero);
        end
      end else if (data !== e.val) begin
        failures++;
        $display("FAIL %s: data=%h expected %h", e.name, data, e.val);
      end
    end
  end

  task automatic expect_bus(input logic [31:0] v, input string n);
    exp_t e;
    e.is_alu = 1'b0; e.val = v; e.zero = 1'b0; e.name = n;
    sb.push_back(e);
  endtask

  task automatic apply(input logic c, input logic w, input logic o,
                       input logic [27:0] a, input logic den, input logic [31:0] dv);
    @(posedge clock);
    #1;
    cs_input = c; we = w; oe = o; addr = a; drv_en = den; drv_val = dv;
  endtask

  task automatic write_word(input logic [27:0] a, input logic [31:0] v);
    apply(1'b1, 1'b1, 1'b0, a, 1'b1, v);
  endtask

  task automatic read_word(input logic [27:0] a, input logic [31:0] v, input string n);
    apply(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0);
    expect_bus(v, n);
  endtask

  task automatic alu_check(input logic [3:0] s, input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] v, input string n);
    exp_t e;
    @(posedge clock);
    #1;
    alu_sel = s; left = l; right = r;
    e.is_alu = 1'b1; e.val = v; e.zero = (v == 32'h0); e.name = n;
    sb.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; cs_input = 1'b1; we = 1'b0; oe = 1'b1; addr = '0;
    drv_en = 1'b0; drv_val = '0; left = '0; right = '0; alu_sel = 4'd0;
    @(posedge clock); #1;
    expect_bus(PULL, "reset_bus_hiz");
    apply(1'b0, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0);
    reset_n = 1'b1;

    write_word(28'h100, 32'h2000_0113);
    write_word(28'h101, 32'h0000_0111);
    read_word(28'h100, 32'h2000_0113, "read_0x100");
    read_word(28'h101, 32'h0000_0111, "read_0x101");

    apply(1'b0, 1'b0, 1'b1, 28'h100, 1'b0, 32'h0);
    expect_bus(PULL, "hiz_cs0");
    apply(1'b1, 1'b0, 1'b1, 28'h100, 1'b0, 32'h0);
    expect_bus(32'h0000_0111, "rdq_hold_idle");
    apply(1'b1, 1'b0, 1'b1, 28'h100, 1'b0, 32'h0);
    expect_bus(32'h2000_0113, "read_0x100_again");
    apply(1'b1, 1'b0, 1'b0, 28'h100, 1'b0, 32'h0);
    expect_bus(PULL, "hiz_oe0");
    apply(1'b1, 1'b1, 1'b1, 28'h1FF, 1'b0, 32'h0);
    expect_bus(PULL, "hiz_we1");

    write_word(28'h115, 32'hFFFF_FFFF);
    read_word(28'h115, 32'hFFFF_FFFF, "read_0x115");
    write_word(28'h114, 32'd10);

    // Reset lands between read setup and its capture edge.
    apply(1'b1, 1'b0, 1'b1, 28'h114, 1'b0, 32'h0);
    #2;
    reset_n = 1'b0;
    expect_bus(PULL, "reset_midread_hiz");
    alu_check(4'b0010, 32'd2, 32'd3, 32'd5, "alu_during_reset");
    write_word(28'h114, 32'h0000_0055);
    apply(1'b1, 1'b0, 1'b1, 28'h114, 1'b0, 32'h0);
    reset_n = 1'b1;
    expect_bus(32'h0, "rdq_zero_after_reset");
    apply(1'b1, 1'b0, 1'b1, 28'h114, 1'b0, 32'h0);
    expect_bus(32'd10, "read_0x114_after_reset");
    read_word(28'h1114, 32'd10, "alias_0x1114");
    apply(1'b0, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0);

    alu_check(4'b0010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "add_wrap");
    alu_check(4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
    alu_check(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg");
    alu_check(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big");
    alu_check(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_pos");
    alu_check(4'b1010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_small");
    alu_check(4'b1000, 32'h8000_0000, 32'd4,         32'hF800_0000, "sra");
    alu_check(4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
    alu_check(4'b0100, 32'h0000_0001, 32'd33,        32'h0000_0002, "sll_mod32");
    alu_check(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
    alu_check(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or");
    alu_check(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
    alu_check(4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, "nor");
    alu_check(4'b1011, 32'h1234_5678, 32'h0000_0009, 32'h1234_5678, "pass_left");
    alu_check(4'b1100, 32'h1234_5678, 32'h0000_0009, 32'h0000_0009, "pass_right");
    alu_check(4'b1101, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, "op_1101");
    alu_check(4'b1111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, "op_1111");

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clock);
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mem_unit.md
ALU_MEM_UNIT -- requirements
Module: alu_mem_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the ALU and the RAM.
REQ-002 Parameter ADDR_WIDTH, default 28, RAM address port width.
REQ-003 Parameter RAM_DEPTH, default 4096, physical word count; addr taken modulo RAM_DEPTH, upper bits ignored.
REQ-004 Ports SHALL be, as `name direction width meaning`:
- clock  in  1  single clock; one clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_WIDTH  RAM word address.
- data  inout  DATA_WIDTH  bidirectional RAM data bus.
- cs_input  in  1  RAM chip select, active high.
- we  in  1  RAM write enable, active high.
- oe  in  1  RAM output enable, active high.
- left  in  32  ALU operand A.
- right  in  32  ALU operand B.
- alu_sel  in  4  ALU operation select.
- alu_out  out  32  ALU result.
- alu_zero  out  1  high when alu_out == 0.

Function
REQ-005 RAM write: at a rising clock with reset_n=1, cs_input=1 and we=1, mem[addr] SHALL be loaded from data.
REQ-006 RAM read: at a rising clock with cs_input=1 and we=0, read register rd_q SHALL capture mem[addr] (one-cycle synchronous latency).
REQ-007 The data bus SHALL be driven with rd_q only when cs_input=1, oe=1 and we=0; otherwise it SHALL be high-Z.
REQ-008 Read-during-write is impossible (we=1 blocks reads); rd_q SHALL hold its value on write and idle cycles.
REQ-009 The ALU SHALL be purely combinational, with zero-cycle latency.
REQ-010 ALU alu_sel encoding:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL by right[4:0]
- 0101 SRL by right[4:0]
- 0110 SUB (left-right)
- 0111 SLT signed (result 1/0)
- 1000 SRA by right[4:0]
- 1001 NOR
- 1010 SLTU
- 1011 pass left
- 1100 pass right
- 1101-1111 result 0
REQ-011 ADD/SUB SHALL wrap modulo 2^32; no carry or overflow output.
REQ-012 The ALU and RAM paths SHALL be independent; ALU ports are not connected to the RAM.
REQ-013 RAM contents SHALL be uninitialised (X) until written.

Reset
REQ-014 While reset_n=0, rd_q SHALL be 0 asynchronously and the data bus SHALL be high-Z.
REQ-015 While reset_n=0, writes SHALL be ignored; memory contents SHALL be preserved across reset.
REQ-016 Reset asserted mid-read SHALL abort the read; the first read after release SHALL have the normal one-cycle latency.
REQ-017 alu_out and alu_zero SHALL be unaffected by reset.

Structure
REQ-018 A shared package SHALL hold the alu_sel opcode constants and the DATA_WIDTH default.
REQ-019 The ALU SHALL be one sub-module named alu; RAM storage and bus control SHALL live in the top level.

Verification
REQ-020 Write test: write 0x20000113 at 0x100 and 0x00000111 at 0x101; read 0x100 with oe=1 -> data=0x20000113 after one edge; then 0x101 -> 0x00000111.
REQ-021 Bus release: cs_input=0, or oe=0, or we=1 -> data is high-Z; bench-driven write 0xFFFFFFFF at 0x115 reads back as 0xFFFFFFFF.
REQ-022 Adder wrap: ADD 1+0xFFFFFFFF -> 0, alu_zero=1; SUB 0-1 -> 0xFFFFFFFF.
REQ-023 Compare and shift:
- SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
- SRA 0x80000000 by 4 -> 0xF8000000.
- SLL 1 by 33 -> 2.
REQ-024 Reset and aliasing:
- Write 10 at 0x114, pulse reset_n low mid-read -> bus high-Z, rd_q=0; after release, read 0x114 -> 10.
- With RAM_DEPTH=4096, addr 0x1114 reads the same word as 0x114.
